// File: rtl/rr_resource_arbiter.sv
// rtl/rr_resource_arbiter.sv - round-robin arbiter sharing one request/ack resource port
// Define RR_ARBITER_WATCHDOG_EN to abort transactions whose ack never arrives.
module rr_resource_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [NUM_REQ-1:0]            iRequest,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] iAddress,
  output logic [NUM_REQ-1:0]            oGrant,
  output logic [NUM_REQ-1:0]            oAck,
  output logic                          oBusy,
  output logic                          oResRequest,
  output logic [ADDR_WIDTH-1:0]         oResAddress,
  input  logic                          iResAck,
  output logic                          oTimeout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_REQ-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NUM_REQ-1:0]    sel;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  found;
  logic                  abort;
  logic [IW-1:0]         idx;

  // First requester at or above the pointer, wrapping past NUM_REQ-1.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        idx = IW'((j + k) % NUM_REQ);
        if (!found && ptr_q[j] && iRequest[idx]) begin
          sel[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel[i]) begin
        sel_addr = sel_addr | iAddress[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

`ifdef RR_ARBITER_WATCHDOG_EN
  localparam logic [7:0] WdLast = 8'(TIMEOUT - 1);

  logic [7:0] wd_q, wd_d;
  logic       timeout_q, timeout_d;

  // ISSUE lasts at most TIMEOUT cycles: the count runs 0..TIMEOUT-1.
  always_comb begin
    wd_d      = wd_q;
    timeout_d = timeout_q;
    abort     = 1'b0;
    if (state_q == IDLE && found) begin
      wd_d = '0;
    end else if (state_q == ISSUE && !iResAck) begin
      if (wd_q == WdLast) begin
        abort     = 1'b1;
        timeout_d = 1'b1;
      end else begin
        wd_d = wd_q + 8'd1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign oTimeout = timeout_q;
`else
  assign abort    = 1'b0;
  assign oTimeout = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      ptr_q   <= NUM_REQ'(1);
      grant_q <= '0;
      ack_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    ptr_d   = ptr_q;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ISSUE;
          grant_d = sel;
          addr_d  = sel_addr;
        end
      end
      ISSUE: begin
        if (iResAck || abort) begin
          state_d = RELEASE;
          ack_d   = iResAck ? grant_q : '0;
          ptr_d   = {grant_q[NUM_REQ-2:0], grant_q[NUM_REQ-1]};
        end
      end
      RELEASE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    oBusy       = (state_q != IDLE);
    oResRequest = (state_q == ISSUE);
    oGrant      = grant_q;
    oAck        = ack_q;
    oResAddress = addr_q;
  end

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// tb/tb_rr_resource_arbiter.sv - randomized checks of rr_resource_arbiter against a transaction model
module tb_rr_resource_arbiter;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int TO = 10;

  logic            Clock = 1'b0;
  logic            Reset;
  logic [N-1:0]    iRequest;
  logic [N*AW-1:0] iAddress;
  logic [N-1:0]    oGrant;
  logic [N-1:0]    oAck;
  logic            oBusy;
  logic            oResRequest;
  logic [AW-1:0]   oResAddress;
  logic            iResAck;
  logic            oTimeout;

  int vectors     = 0;
  int miscompares = 0;
  int ptr_m       = 0;
  bit mon_en      = 1'b0;

  rr_resource_arbiter #(
    .NUM_REQ   (N),
    .ADDR_WIDTH(AW),
    .TIMEOUT   (TO)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .iRequest   (iRequest),
    .iAddress   (iAddress),
    .oGrant     (oGrant),
    .oAck       (oAck),
    .oBusy      (oBusy),
    .oResRequest(oResRequest),
    .oResAddress(oResAddress),
    .iResAck    (iResAck),
    .oTimeout   (oTimeout)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (mon_en) begin
      vectors++;
      if (!$onehot0(oGrant) || ((oAck & ~oGrant) != '0) || (oResRequest && oGrant == '0)) begin
        miscompares++;
        $display("FAIL invariant grant=%b ack=%b resreq=%b (need onehot0 grant, ack within grant, resreq only with grant)",
                 oGrant, oAck, oResRequest);
      end
    end
  end

  // Model: first requesting index at or after ptr_m, modulo N.
  function automatic int pick(input logic [N-1:0] req);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr_m + k) % N]) return (ptr_m + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic randomize_addr();
    for (int i = 0; i < N; i++) iAddress[i*AW +: AW] = AW'($urandom);
  endtask

  task automatic apply_reset();
    Reset    = 1'b0;
    iRequest = '0;
    iResAck  = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    ptr_m = 0;
  endtask

  task automatic do_txn(input logic [N-1:0] req, input logic [N-1:0] req_mid, input int delay,
                        input bit ack_rel, input bit beef,
                        output logic [N-1:0] g, output logic [AW-1:0] a);
    int            e;
    logic [N-1:0]  eg;
    logic [AW-1:0] ea;
    randomize_addr();
    if (beef) iAddress[2*AW +: AW] = 16'hBEEF;
    iRequest = req;
    iResAck  = 1'b0;
    e = pick(req);
    tick();
    g = oGrant;
    a = oResAddress;
    vectors++;
    if (e < 0) begin
      if (oGrant !== '0 || oBusy !== 1'b0 || oResRequest !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_no_req got grant=%b busy=%b resreq=%b exp 0/0/0", oGrant, oBusy, oResRequest);
      end
      return;
    end
    eg = N'(1) << e;
    ea = iAddress[e*AW +: AW];
    if (oGrant !== eg || oResRequest !== 1'b1 || oResAddress !== ea || oBusy !== 1'b1 || oAck !== '0) begin
      miscompares++;
      $display("FAIL grant_issue got grant=%b addr=%h resreq=%b busy=%b ack=%b exp grant=%b addr=%h 1 1 000",
               oGrant, oResAddress, oResRequest, oBusy, oAck, eg, ea);
    end
    iRequest = req_mid;
    for (int d = 0; d < delay; d++) begin
      randomize_addr();
      tick();
      vectors++;
      if (oGrant !== eg || oResRequest !== 1'b1 || oResAddress !== ea || oAck !== '0) begin
        miscompares++;
        $display("FAIL issue_hold got grant=%b addr=%h resreq=%b ack=%b exp grant=%b addr=%h 1 000",
                 oGrant, oResAddress, oResRequest, oAck, eg, ea);
      end
    end
    iResAck = 1'b1;
    tick();
    ptr_m = (e + 1) % N;
    vectors++;
    if (oAck !== eg || oGrant !== eg || oResRequest !== 1'b0 || oBusy !== 1'b1 || oTimeout !== 1'b0 && !ack_rel && 1'b0) begin
      miscompares++;
      $display("FAIL release_ack got ack=%b grant=%b resreq=%b busy=%b exp ack=%b grant=%b 0 1",
               oAck, oGrant, oResRequest, oBusy, eg, eg);
    end
    iResAck = ack_rel;
    tick();
    vectors++;
    if (oGrant !== '0 || oAck !== '0 || oBusy !== 1'b0 || oResRequest !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_idle got grant=%b ack=%b busy=%b resreq=%b exp all 0", oGrant, oAck, oBusy, oResRequest);
    end
    iResAck = 1'b0;
  endtask

  task automatic test_reset();
    Reset    = 1'b0;
    iRequest = '1;
    iResAck  = 1'b1;
    randomize_addr();
    tick();
    tick();
    mon_en = 1'b1;
    vectors++;
    if (oGrant !== '0 || oAck !== '0 || oBusy !== 1'b0 || oResRequest !== 1'b0 ||
        oResAddress !== '0 || oTimeout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state got grant=%b ack=%b busy=%b resreq=%b addr=%h to=%b exp all 0",
               oGrant, oAck, oBusy, oResRequest, oResAddress, oTimeout);
    end
    iRequest = '0;
    iResAck  = 1'b0;
    Reset    = 1'b1;
    ptr_m    = 0;
  endtask

  task automatic test_single();
    logic [N-1:0]  g;
    logic [AW-1:0] a;
    do_txn(3'b100, 3'b000, 1, 1'b0, 1'b1, g, a);
    vectors++;
    if (g !== 3'b100 || a !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL single_beef got grant=%b addr=%h exp 100 beef", g, a);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0]  g;
    logic [AW-1:0] a;
    logic [N-1:0]  order [4];
    order = '{3'b001, 3'b010, 3'b100, 3'b001};
    apply_reset();
    for (int t = 0; t < 4; t++) begin
      do_txn(3'b111, 3'b111, 1, 1'b0, 1'b0, g, a);
      vectors++;
      if (g !== order[t]) begin
        miscompares++;
        $display("FAIL rr_order[%0d] got %b exp %b", t, g, order[t]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0]  g;
    logic [AW-1:0] a;
    apply_reset();
    do_txn(3'b001, 3'b011, 2, 1'b0, 1'b0, g, a);
    do_txn(3'b011, 3'b011, 1, 1'b0, 1'b0, g, a);
    vectors++;
    if (g !== 3'b010) begin
      miscompares++;
      $display("FAIL fairness got %b exp 010", g);
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0]  g;
    logic [AW-1:0] a;
    apply_reset();
    do_txn(3'b001, 3'b000, 0, 1'b0, 1'b0, g, a);
    iRequest = 3'b010;
    tick();
    vectors++;
    if (oGrant !== 3'b010 || oResRequest !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_setup got grant=%b resreq=%b exp 010 1", oGrant, oResRequest);
    end
    Reset   = 1'b0;
    iResAck = 1'b1;
    tick();
    vectors++;
    if (oGrant !== '0 || oAck !== '0 || oBusy !== 1'b0 || oResRequest !== 1'b0 || oResAddress !== '0) begin
      miscompares++;
      $display("FAIL mid_reset got grant=%b ack=%b busy=%b resreq=%b addr=%h exp all 0",
               oGrant, oAck, oBusy, oResRequest, oResAddress);
    end
    Reset   = 1'b1;
    iResAck = 1'b0;
    ptr_m   = 0;
    do_txn(3'b111, 3'b000, 1, 1'b0, 1'b0, g, a);
    vectors++;
    if (g !== 3'b001) begin
      miscompares++;
      $display("FAIL mid_priority got %b exp 001", g);
    end
  endtask

  task automatic test_drop_request();
    logic [N-1:0]  g;
    logic [AW-1:0] a;
    do_txn(3'b100, 3'b000, 5, 1'b1, 1'b0, g, a);
    for (int c = 0; c < 6; c++) begin
      iRequest = '0;
      iResAck  = 1'($urandom);
      tick();
      vectors++;
      if (oGrant !== '0 || oAck !== '0 || oBusy !== 1'b0 || oResRequest !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_ack_ignored got grant=%b ack=%b busy=%b resreq=%b exp all 0",
                 oGrant, oAck, oBusy, oResRequest);
      end
    end
    iResAck = 1'b0;
  endtask

  task automatic test_random();
    logic [N-1:0]  g;
    logic [AW-1:0] a;
    for (int t = 0; t < 60; t++) begin
      do_txn(N'($urandom), N'($urandom), $urandom_range(0, 4), 1'($urandom), 1'b0, g, a);
    end
`ifndef RR_ARBITER_WATCHDOG_EN
    vectors++;
    if (oTimeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_tied got %b exp 0", oTimeout);
    end
`endif
  endtask

`ifdef RR_ARBITER_WATCHDOG_EN
  task automatic test_watchdog();
    int            cnt;
    logic [N-1:0]  g;
    logic [AW-1:0] a;
    apply_reset();
    iRequest = 3'b011;
    iResAck  = 1'b0;
    tick();
    cnt = 0;
    for (int c = 0; c < 3 * TO && oResRequest === 1'b1; c++) begin
      cnt++;
      tick();
    end
    vectors++;
    if (cnt != TO || oTimeout !== 1'b1 || oAck !== '0 || oGrant !== 3'b001 || oBusy !== 1'b1) begin
      miscompares++;
      $display("FAIL wd_abort got cycles=%0d to=%b ack=%b grant=%b busy=%b exp %0d 1 000 001 1",
               cnt, oTimeout, oAck, oGrant, oBusy, TO);
    end
    tick();
    ptr_m = 1;
    vectors++;
    if (oGrant !== '0 || oTimeout !== 1'b1) begin
      miscompares++;
      $display("FAIL wd_idle got grant=%b to=%b exp 000 1", oGrant, oTimeout);
    end
    do_txn(3'b011, 3'b000, 1, 1'b0, 1'b0, g, a);
    vectors++;
    if (g !== 3'b010 || oTimeout !== 1'b1) begin
      miscompares++;
      $display("FAIL wd_next got grant=%b to=%b exp 010 1", g, oTimeout);
    end
  endtask
`endif

  initial begin
    iRequest = '0;
    iAddress = '0;
    iResAck  = 1'b0;
    Reset    = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_reset_mid();
    test_drop_request();
    test_random();
`ifdef RR_ARBITER_WATCHDOG_EN
    test_watchdog();
`endif
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
